fft_out_reorder: RTL and testbench



---
 rtl/fft_pkg.sv | 27 ++
 rtl/fft_reorder_bank.sv | 42 ++++
 rtl/fft_out_reorder.sv | 172 +++++++++++++++++
 tb/tb_fft_out_reorder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, types and helpers for the 32-point MDC FFT datapath.
package fft_pkg;

   localparam int unsigned FFT_N     = 32;
   localparam int unsigned FFT_LOG2N = 5;
   localparam int unsigned FFT_DW    = 9;

   typedef struct packed {
      logic signed [FFT_DW-1:0] re;
      logic signed [FFT_DW-1:0] im;
   } cplx_t;

   typedef enum logic {
      RD_IDLE,
      RD_DRAIN
   } rd_state_e;

   function automatic logic [FFT_LOG2N-1:0] bitrev5(input logic [FFT_LOG2N-1:0] x);
      logic [FFT_LOG2N-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < FFT_LOG2N; i++) begin
         r[i] = x[FFT_LOG2N-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One ping/pong half of the reorder buffer: even/odd sub-banks written as a
// pair each beat, one registered read port, active only when selected.
module fft_reorder_bank
   import fft_pkg::*;
#(
   parameter int unsigned DATA_W  = FFT_DW,
   parameter bit          BANK_ID = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic                   wsel,
   input  logic [FFT_LOG2N-2:0]   wr_pair,
   input  logic [2*DATA_W-1:0]    wr_even,
   input  logic [2*DATA_W-1:0]    wr_odd,
   input  logic                   rd_en,
   input  logic                   rsel,
   input  logic [FFT_LOG2N-1:0]   rd_addr,
   output logic [2*DATA_W-1:0]    rd_data
);

   logic [2*DATA_W-1:0] mem_even [FFT_N/2];
   logic [2*DATA_W-1:0] mem_odd  [FFT_N/2];

   always_ff @(posedge clk) begin
      if (wr_en && (wsel == BANK_ID)) begin
         mem_even[wr_pair] <= wr_even;
         mem_odd[wr_pair]  <= wr_odd;
      end
   end

   // Address bit 0 picks the sub-bank, the upper bits index within it.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en && (rsel == BANK_ID)) begin
         rd_data <= rd_addr[0] ? mem_odd[rd_addr[FFT_LOG2N-1:1]]
                               : mem_even[rd_addr[FFT_LOG2N-1:1]];
      end
   end

endmodule

// File: rtl/fft_out_reorder.sv
// FFT output stage: captures bit-reversed Up/Down lane pairs into a ping-pong
// buffer and replays each frame as one natural-order bin per clock.
module fft_out_reorder
   import fft_pkg::*;
#(
   parameter int unsigned DATA_W = FFT_DW,
   parameter int unsigned N      = FFT_N
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_W-1:0]     MDCOutUpRe,
   input  logic [DATA_W-1:0]     MDCOutUpIm,
   input  logic [DATA_W-1:0]     MDCOutDownRe,
   input  logic [DATA_W-1:0]     MDCOutDownIm,
   output logic [DATA_W-1:0]     FFTOutRe,
   output logic [DATA_W-1:0]     FFTOutIm,
   output logic                  out_valid,
   output logic [FFT_LOG2N-1:0]  out_index,
   output logic                  out_last,
   output logic                  overflow
);

   localparam int unsigned AW = FFT_LOG2N;
   localparam logic [AW-2:0] K_LAST = (AW-1)'(N/2 - 1);
   localparam logic [AW-1:0] A_LAST = AW'(N - 1);

   logic [AW-2:0]       k;
   logic                wsel;
   logic                rsel;
   logic                rbank;
   logic [1:0]          full;
   logic [1:0]          full_nxt;
   rd_state_e           state;
   logic [AW-1:0]       rd_addr;
   logic                issue;
   logic                drain_end;
   logic                wr_blocked;
   logic                accept;
   logic                fill_done;
   logic                wr_en;
   logic [AW-2:0]       wr_pair;
   logic [2*DATA_W-1:0] wr_even;
   logic [2*DATA_W-1:0] wr_odd;
   logic [2*DATA_W-1:0] rd_data0;
   logic [2*DATA_W-1:0] rd_data1;
   logic [2*DATA_W-1:0] rd_word;

   assign issue     = (state == RD_DRAIN);
   assign drain_end = issue && (rd_addr == A_LAST);

   // A bank being released this cycle already counts as free for the writer.
   assign wr_blocked = full[wsel] && !(drain_end && (rsel == wsel));
   assign accept     = in_valid && !wr_blocked;
   assign fill_done  = accept && (k == K_LAST);
   assign wr_en      = accept && !rst;

   // Up lane carries even bin bitrev5(k); the pair index drops its zero LSB.
   assign wr_pair = (AW-1)'(bitrev5({1'b0, k}) >> 1);
   assign wr_even = {MDCOutUpRe, MDCOutUpIm};
   assign wr_odd  = {MDCOutDownRe, MDCOutDownIm};

   always_comb begin
      full_nxt = full;
      if (drain_end) begin
         full_nxt[rsel] = 1'b0;
      end
      if (fill_done) begin
         full_nxt[wsel] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         k        <= '0;
         wsel     <= 1'b0;
         full     <= '0;
         overflow <= 1'b0;
      end else begin
         full <= full_nxt;
         if (accept) begin
            if (fill_done) begin
               k    <= '0;
               wsel <= ~wsel;
            end else begin
               k <= k + 1'b1;
            end
         end
         if (in_valid && wr_blocked) begin
            overflow <= 1'b1;
         end
      end
   end

   // Decisions look at full_nxt so a frame completing this cycle starts
   // draining on the very next one, with no idle gap between banks.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RD_IDLE;
         rd_addr   <= '0;
         rsel      <= 1'b0;
         rbank     <= 1'b0;
         out_valid <= 1'b0;
         out_index <= '0;
         out_last  <= 1'b0;
      end else begin
         out_valid <= issue;
         out_last  <= drain_end;
         if (issue) begin
            out_index <= rd_addr;
            rbank     <= rsel;
         end
         case (state)
            RD_IDLE: begin
               if (full_nxt[rsel]) begin
                  state   <= RD_DRAIN;
                  rd_addr <= '0;
               end
            end
            RD_DRAIN: begin
               if (drain_end) begin
                  rsel    <= ~rsel;
                  rd_addr <= '0;
                  state   <= full_nxt[~rsel] ? RD_DRAIN : RD_IDLE;
               end else begin
                  rd_addr <= rd_addr + 1'b1;
               end
            end
            default: state <= RD_IDLE;
         endcase
      end
   end

   fft_reorder_bank #(
      .DATA_W  (DATA_W),
      .BANK_ID (1'b0)
   ) u_bank0 (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wsel    (wsel),
      .wr_pair (wr_pair),
      .wr_even (wr_even),
      .wr_odd  (wr_odd),
      .rd_en   (issue),
      .rsel    (rsel),
      .rd_addr (rd_addr),
      .rd_data (rd_data0)
   );

   fft_reorder_bank #(
      .DATA_W  (DATA_W),
      .BANK_ID (1'b1)
   ) u_bank1 (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wsel    (wsel),
      .wr_pair (wr_pair),
      .wr_even (wr_even),
      .wr_odd  (wr_odd),
      .rd_en   (issue),
      .rsel    (rsel),
      .rd_addr (rd_addr),
      .rd_data (rd_data1)
   );

   assign rd_word  = rbank ? rd_data1 : rd_data0;
   assign FFTOutRe = rd_word[2*DATA_W-1:DATA_W];
   assign FFTOutIm = rd_word[DATA_W-1:0];

endmodule

// File: tb/tb_fft_out_reorder.sv
// Bench for fft_out_reorder: frames of bins are driven in bit-reversed lane
// pairs and the output stream is scored against natural bin order.
module tb_fft_out_reorder;

   localparam int DW = 9;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst;
   logic                 in_valid;
   logic signed [DW-1:0] up_re, up_im, dn_re, dn_im;
   logic signed [DW-1:0] out_re, out_im;
   logic                 out_valid, out_last, overflow;
   logic [4:0]           out_index;

   fft_out_reorder #(
      .DATA_W (DW),
      .N      (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .MDCOutUpRe   (up_re),
      .MDCOutUpIm   (up_im),
      .MDCOutDownRe (dn_re),
      .MDCOutDownIm (dn_im),
      .FFTOutRe     (out_re),
      .FFTOutIm     (out_im),
      .out_valid    (out_valid),
      .out_index    (out_index),
      .out_last     (out_last),
      .overflow     (overflow)
   );

   typedef struct {
      int                   idx;
      logic signed [DW-1:0] re;
      logic signed [DW-1:0] im;
      bit                   last;
   } exp_t;

   exp_t                 exp_q[$];
   int                   checks = 0;
   int                   errors = 0;
   int                   run_len = 0;
   int                   max_run = 0;
   logic signed [DW-1:0] fre [32];
   logic signed [DW-1:0] fim [32];

   function automatic int brev5(input int x);
      int r = 0;
      for (int i = 0; i < 5; i++) begin
         if ((x >> i) % 2 == 1) r = r + (1 << (4 - i));
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_out_last"},  32'(out_last),  32'd0);
      chk({tag, "_out_index"}, 32'(out_index), 32'd0);
      chk({tag, "_re"},        32'(out_re),    32'd0);
      chk({tag, "_im"},        32'(out_im),    32'd0);
      chk({tag, "_overflow"},  32'(overflow),  32'd0);
   endtask

   task automatic rand_frame();
      for (int i = 0; i < 32; i++) begin
         fre[i] = 9'($urandom());
         fim[i] = 9'($urandom());
      end
   endtask

   task automatic push_expected();
      for (int i = 0; i < 32; i++) begin
         exp_q.push_back('{idx: i, re: fre[i], im: fim[i], last: (i == 31)});
      end
   endtask

   // Called and returns at #1 after a rising edge.
   task automatic send_frame(input bit gaps, input int tail_idle, input int nbeats);
      for (int k = 0; k < nbeats; k++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
               in_valid = 1'b0;
               @(posedge clk); #1;
            end
         end
         in_valid = 1'b1;
         up_re = fre[brev5(k)];
         up_im = fim[brev5(k)];
         dn_re = fre[brev5(k) + 1];
         dn_im = fim[brev5(k) + 1];
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (tail_idle) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         exp_t e;
         run_len++;
         if (run_len > max_run) max_run = run_len;
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_output: observed bin %0d, expected no output", out_index);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            assert ({out_index, out_re, out_im, out_last} === {5'(e.idx), e.re, e.im, e.last}) else begin
               errors++;
               $error("FAIL bin_data: observed idx %0d re %0d im %0d last %0b, expected idx %0d re %0d im %0d last %0b",
                      out_index, out_re, out_im, out_last, e.idx, e.re, e.im, e.last);
            end
         end
      end else begin
         run_len = 0;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      rst = 1'b1;
      in_valid = 1'b0;
      up_re = '0; up_im = '0; dn_re = '0; dn_im = '0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Ramp frame: Re = bin, Im = -bin, plus first-output latency.
      for (int i = 0; i < 32; i++) begin
         fre[i] = 9'(i);
         fim[i] = 9'(-i);
      end
      push_expected();
      send_frame(1'b0, 0, 16);
      @(negedge clk);
      chk("latency_t1_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("latency_t2_valid", 32'(out_valid), 32'd1);
      chk("latency_t2_index", 32'(out_index), 32'd0);
      wait_drain("ramp");

      // Spectrum of an impulse of height 64.
      for (int i = 0; i < 32; i++) begin
         fre[i] = 9'sd64;
         fim[i] = 9'sd0;
      end
      push_expected();
      send_frame(1'b0, 0, 16);
      wait_drain("impulse");

      // Gapped then gap-free delivery of the same random frame.
      rand_frame();
      push_expected();
      send_frame(1'b1, 0, 16);
      wait_drain("gapped");
      push_expected();
      send_frame(1'b0, 0, 16);
      wait_drain("gapfree");

      // Four frames at one frame per 32 cycles.
      max_run = 0;
      for (int f = 0; f < 4; f++) begin
         rand_frame();
         push_expected();
         send_frame(1'b0, 16, 16);
      end
      wait_drain("b2b");
      chk("b2b_valid_run", 32'(max_run), 32'd128);
      chk("b2b_overflow", 32'(overflow), 32'd0);

      // Three frames back to back: the third cannot be stored.
      rand_frame();
      push_expected();
      send_frame(1'b0, 0, 16);
      rand_frame();
      push_expected();
      send_frame(1'b0, 0, 16);
      rand_frame();
      send_frame(1'b0, 0, 16);
      wait_drain("overflow_frames");
      repeat (40) @(posedge clk);
      #1;
      chk("overflow_flag", 32'(overflow), 32'd1);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check_zero("overflow_reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // Reset while bin 10 is on the output.
      rand_frame();
      push_expected();
      send_frame(1'b0, 0, 16);
      found = 1'b0;
      for (int n = 0; n < 80 && !found; n++) begin
         @(negedge clk);
         if (out_valid === 1'b1 && out_index == 5'd10) found = 1'b1;
      end
      chk("mid_drain_bin10_seen", 32'(found), 32'd1);
      #1;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      check_zero("mid_drain_reset");
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      rand_frame();
      push_expected();
      send_frame(1'b0, 0, 16);
      wait_drain("after_drain_reset");

      // Reset partway through a fill; the partial frame must vanish.
      rand_frame();
      send_frame(1'b0, 0, 7);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      rand_frame();
      push_expected();
      send_frame(1'b1, 0, 16);
      wait_drain("after_fill_reset");
      repeat (40) @(posedge clk);
      #1;
      chk("final_overflow", 32'(overflow), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
